// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the fetch PC, prefetch FIFO toward decode,
// and shares the ROM address bus with a debug read port.
module fetch_sequencer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int DBG_MAXWAIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int WW = $clog2(DBG_MAXWAIT + 1) > 0 ? $clog2(DBG_MAXWAIT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HALT
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_mem_d [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_mem_a [FIFO_DEPTH];
  logic [PW-1:0]     r_rd;
  logic [PW-1:0]     r_wr;
  logic [CW-1:0]     r_cnt;
  logic [WW-1:0]     r_wait;
  logic              r_dbg_ack;
  logic [DATA_W-1:0] r_dbg_data;

  logic w_full;
  logic w_pop;
  logic w_idle;
  logic w_grant;
  logic w_fire;

  assign instr_valid = (r_cnt != '0);
  assign instr       = r_mem_d[r_rd];
  assign instr_pc    = r_mem_a[r_rd];
  assign dbg_ack     = r_dbg_ack;
  assign dbg_data    = r_dbg_data;

  assign w_full  = (r_cnt == CW'(FIFO_DEPTH));
  assign w_pop   = instr_valid & instr_ready;
  assign w_idle  = (r_state != S_FETCH) | halt | (w_full & ~w_pop);
  // Gated by rst_n so the bus shows RESET_PC throughout reset
  assign w_grant = rst_n & dbg_req & ~r_dbg_ack &
                   (w_idle | (r_wait == WW'(DBG_MAXWAIT)));
  assign w_fire  = (r_state == S_FETCH) & ~halt & ~redirect_valid &
                   ~w_grant & (~w_full | w_pop);

  assign rom_addr = w_grant ? dbg_addr : r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  r_state <= halt ? S_HALT : S_FETCH;
        S_FETCH: if (halt) r_state <= S_HALT;
        S_HALT:  if (!halt) r_state <= S_FETCH;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc  <= RESET_PC;
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_d[i] <= '0;
        r_mem_a[i] <= '0;
      end
    end else if (redirect_valid) begin
      r_pc  <= redirect_pc & ~ADDR_W'(1);
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_fire) begin
        r_mem_d[r_wr] <= rom_data;
        r_mem_a[r_wr] <= r_pc;
        r_wr          <= r_wr + PW'(1);
        r_pc          <= r_pc + ADDR_W'(2);
      end
      if (w_pop) r_rd <= r_rd + PW'(1);
      r_cnt <= r_cnt + CW'(w_fire) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait     <= '0;
      r_dbg_ack  <= 1'b0;
      r_dbg_data <= '0;
    end else begin
      r_dbg_ack <= w_grant;
      if (w_grant) begin
        r_dbg_data <= rom_data;
        r_wait     <= '0;
      end else if (dbg_req && !r_dbg_ack &&
                   r_wait != WW'(DBG_MAXWAIT)) begin
        r_wait <= r_wait + WW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: ROM model returns addr ^ 16'hA5A5.
// Table of per-cycle vectors plus directed wrap/halt/debug/reset cases.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        dbg_req;
  logic [15:0] dbg_addr;
  logic        dbg_ack;
  logic [15:0] dbg_data;

  int errors = 0;
  int checks = 0;

  fetch_sequencer dut (
    .clk(clk),
    .rst_n(rst_n),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halt(halt),
    .dbg_req(dbg_req),
    .dbg_addr(dbg_addr),
    .dbg_ack(dbg_ack),
    .dbg_data(dbg_data)
  );

  assign rom_data = rom_addr ^ 16'hA5A5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [15:0] rpc;
    logic        ev;
    logic [15:0] epc;
    logic [15:0] eins;
    logic [15:0] erom;
  } vec_t;

  vec_t tv[16];

  initial begin
    tv[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000};
    tv[1]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'hA5A5, 16'h0002};
    tv[2]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'hA5A7, 16'h0004};
    tv[3]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'hA5A1, 16'h0006};
    tv[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 16'hA5A3, 16'h0008};
    tv[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 16'hA5A3, 16'h000A};
    tv[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 16'hA5A3, 16'h000A};
    tv[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 16'hA5A3, 16'h000A};
    tv[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 16'hA5A3, 16'h000A};
    tv[9]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0006, 16'hA5A3, 16'h000A};
    tv[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0008, 16'hA5AD, 16'h000C};
    tv[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h000A, 16'hA5AF, 16'h000E};
    tv[12] = '{1'b1, 1'b1, 16'h0041, 1'b1, 16'h000A, 16'hA5AF, 16'h000E};
    tv[13] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0040};
    tv[14] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0040, 16'hA5E5, 16'h0042};
    tv[15] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0042, 16'hA5E7, 16'h0044};

    rst_n = 1'b0;
    instr_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    halt = 1'b0;
    dbg_req = 1'b0;
    dbg_addr = 16'h1234;

    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_pc", 32'(instr_pc), 0);
    chk("rst_ack", 32'(dbg_ack), 0);
    chk("rst_dbgdata", 32'(dbg_data), 0);
    chk("rst_romaddr", 32'(rom_addr), 0);
    rst_n = 1'b1;

    // First vector is the cycle after IDLE -> FETCH
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(tv[i].ev));
      chk($sformatf("v%0d_rom", i), 32'(rom_addr), 32'(tv[i].erom));
      if (tv[i].ev) begin
        chk($sformatf("v%0d_pc", i), 32'(instr_pc), 32'(tv[i].epc));
        chk($sformatf("v%0d_instr", i), 32'(instr), 32'(tv[i].eins));
      end
      instr_ready = tv[i].rdy;
      redirect_valid = tv[i].redir;
      redirect_pc = tv[i].rpc;
    end

    // PC wrap 0xFFFE -> 0x0000
    @(negedge clk);
    chk("pre_wrap_pc", 32'(instr_pc), 32'h0044);
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFE;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("wrap_flush", 32'(instr_valid), 0);
    chk("wrap_rom", 32'(rom_addr), 32'hFFFE);
    @(negedge clk);
    chk("wrap_pc0", 32'(instr_pc), 32'hFFFE);
    chk("wrap_ins0", 32'(instr), 32'h5A5B);
    chk("wrap_rom1", 32'(rom_addr), 32'h0000);
    @(negedge clk);
    chk("wrap_pc1", 32'(instr_pc), 32'h0000);
    chk("wrap_ins1", 32'(instr), 32'hA5A5);

    // Halt, drain, debug read
    @(negedge clk);
    chk("halt_head", 32'(instr_pc), 32'h0002);
    halt = 1'b1;
    @(negedge clk);
    chk("halt_drained", 32'(instr_valid), 0);
    chk("halt_ack0", 32'(dbg_ack), 0);
    dbg_req = 1'b1;
    dbg_addr = 16'h1234;
    #1;
    chk("halt_grant_addr", 32'(rom_addr), 32'h1234);
    @(negedge clk);
    chk("halt_ack", 32'(dbg_ack), 1);
    chk("halt_dbgdata", 32'(dbg_data), 32'hB791);
    dbg_req = 1'b0;
    @(negedge clk);
    chk("halt_ack_pulse", 32'(dbg_ack), 0);
    chk("halt_novalid", 32'(instr_valid), 0);

    // Resume with a redirect, then a continuous debug request
    halt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    dbg_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("starve_k%0d", k), 32'(rom_addr == 16'h1234),
          32'(k == 3));
      chk($sformatf("starve_ack_k%0d", k), 32'(dbg_ack), 0);
    end
    @(negedge clk);
    chk("starve_ack", 32'(dbg_ack), 1);
    chk("starve_data", 32'(dbg_data), 32'hB791);
    chk("starve_empty", 32'(instr_valid), 0);
    dbg_req = 1'b0;
    @(negedge clk);
    chk("resume_valid", 32'(instr_valid), 1);
    chk("resume_pc", 32'(instr_pc), 32'h0106);
    chk("resume_ack0", 32'(dbg_ack), 0);
    @(negedge clk);
    chk("resume_pc2", 32'(instr_pc), 32'h0108);
    chk("resume_ins2", 32'(instr), 32'hA4AD);

    // Asynchronous reset mid-run
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(instr_valid), 0);
    chk("arst_pc", 32'(instr_pc), 0);
    chk("arst_instr", 32'(instr), 0);
    chk("arst_rom", 32'(rom_addr), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
